// File: rtl/alu_control_pipe_pkg.sv
// Shared encodings for the pipelined ALU control decoder:
// alu_op classes, R-type func codes, ALU control codes and FSM states.
package alu_ctrl_pkg;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;
    localparam logic [2:0] ALUOP_LUI   = 3'b110;
    localparam logic [2:0] ALUOP_ILL   = 3'b111;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_SLL  = 4'b1000;
    localparam logic [3:0] CTRL_SRL  = 4'b1001;
    localparam logic [3:0] CTRL_LUI  = 4'b1010;
    localparam logic [3:0] CTRL_NOR  = 4'b1100;
    localparam logic [3:0] CTRL_PASS = 4'b1111;

    typedef enum logic {
        IDLE    = 1'b0,
        MD_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/alu_control_pipe_if.sv
// Decode-side handshake, output beat and mult/div launch signals.
// slave = the decoder block, master = whoever drives it.
interface alu_control_pipe_if #(
    parameter int FUNC_W   = 6,
    parameter int ALU_OP_W = 3,
    parameter int CTRL_W   = 4
);
    logic                valid_in;
    logic                ready_out;
    logic [FUNC_W-1:0]   func;
    logic [ALU_OP_W-1:0] alu_op;
    logic                valid_out;
    logic                stall_in;
    logic [CTRL_W-1:0]   alu_ctrl;
    logic                illegal;
    logic                md_start;
    logic                md_op;
    logic                md_done;
    logic                busy;

    modport slave (
        input  valid_in, func, alu_op, stall_in, md_done,
        output ready_out, valid_out, alu_ctrl, illegal,
        output md_start, md_op, busy
    );

    modport master (
        output valid_in, func, alu_op, stall_in, md_done,
        input  ready_out, valid_out, alu_ctrl, illegal,
        input  md_start, md_op, busy
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational map of alu_op/func to ALU control code,
// mult/div detection and the illegal-op flag.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int FUNC_W   = 6,
    parameter int ALU_OP_W = 3,
    parameter int CTRL_W   = 4
) (
    input  logic [FUNC_W-1:0]   func,
    input  logic [ALU_OP_W-1:0] alu_op,
    output logic [CTRL_W-1:0]   ctrl,
    output logic                is_md,
    output logic                md_op,
    output logic                illegal
);

    always_comb begin
        ctrl    = CTRL_ADD;
        is_md   = 1'b0;
        md_op   = 1'b0;
        illegal = 1'b0;
        unique case (alu_op)
            ALUOP_ADD: ctrl = CTRL_ADD;
            ALUOP_SUB: ctrl = CTRL_SUB;
            ALUOP_AND: ctrl = CTRL_AND;
            ALUOP_OR:  ctrl = CTRL_OR;
            ALUOP_SLT: ctrl = CTRL_SLT;
            ALUOP_LUI: ctrl = CTRL_LUI;
            ALUOP_ILL: illegal = 1'b1;
            ALUOP_RTYPE: begin
                unique case (func)
                    FN_ADD:  ctrl = CTRL_ADD;
                    FN_SUB:  ctrl = CTRL_SUB;
                    FN_AND:  ctrl = CTRL_AND;
                    FN_OR:   ctrl = CTRL_OR;
                    FN_NOR:  ctrl = CTRL_NOR;
                    FN_SLT:  ctrl = CTRL_SLT;
                    FN_SLL:  ctrl = CTRL_SLL;
                    FN_SRL:  ctrl = CTRL_SRL;
                    FN_MFHI: ctrl = CTRL_PASS;
                    FN_MFLO: ctrl = CTRL_PASS;
                    FN_MULT: begin
                        ctrl  = CTRL_PASS;
                        is_md = 1'b1;
                    end
                    FN_DIV: begin
                        ctrl  = CTRL_PASS;
                        is_md = 1'b1;
                        md_op = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_control_pipe.sv
// Registered ALU control stage: valid/ready output register plus a
// two-state sequencer that launches mult/div and holds issue until done.
module alu_control_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int FUNC_W   = 6,
    parameter int ALU_OP_W = 3,
    parameter int CTRL_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_control_pipe_if.slave   io
);

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic                ill_q, ill_d;
    logic                md_start_q, md_start_d;
    logic                md_op_q, md_op_d;
    logic                done_q, done_d;

    logic [CTRL_W-1:0]   dec_ctrl;
    logic                dec_is_md;
    logic                dec_md_op;
    logic                dec_ill;

    logic                free;
    logic                ready;
    logic                accept;
    logic                md_fin;

    alu_ctrl_decode #(
        .FUNC_W   (FUNC_W),
        .ALU_OP_W (ALU_OP_W),
        .CTRL_W   (CTRL_W)
    ) u_dec (
        .func    (io.func),
        .alu_op  (io.alu_op),
        .ctrl    (dec_ctrl),
        .is_md   (dec_is_md),
        .md_op   (dec_md_op),
        .illegal (dec_ill)
    );

    assign free   = !valid_q || !io.stall_in;
    assign ready  = (state_q == IDLE) && free;
    assign accept = io.valid_in && ready;
    // completion may arrive this cycle or have been latched earlier
    assign md_fin = (state_q == MD_WAIT) && (done_q || io.md_done) && free;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            ill_q      <= 1'b0;
            md_start_q <= 1'b0;
            md_op_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            ill_q      <= ill_d;
            md_start_q <= md_start_d;
            md_op_q    <= md_op_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && dec_is_md) state_d = MD_WAIT;
            MD_WAIT: if (md_fin) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        ill_d      = ill_q;
        md_start_d = accept && dec_is_md;
        md_op_d    = accept && dec_is_md && dec_md_op;
        done_d     = 1'b0;
        if (free) valid_d = 1'b0;
        if (accept && !dec_is_md) begin
            valid_d = 1'b1;
            ctrl_d  = dec_ctrl;
            ill_d   = dec_ill;
        end
        if (state_q == MD_WAIT) begin
            done_d = done_q || io.md_done;
            if (md_fin) begin
                valid_d = 1'b1;
                ctrl_d  = CTRL_PASS;
                ill_d   = 1'b0;
                done_d  = 1'b0;
            end
        end
    end

    assign io.ready_out = ready;
    assign io.valid_out = valid_q;
    assign io.alu_ctrl  = ctrl_q;
    assign io.illegal   = ill_q;
    assign io.md_start  = md_start_q;
    assign io.md_op     = md_op_q;
    assign io.busy      = (state_q == MD_WAIT);

endmodule

// File: tb/tb_alu_control_pipe.sv
// Directed bench for alu_control_pipe: decode table streamed
// back-to-back, then stall, mult/div and reset-in-wait sequences.
module tb_alu_control_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_control_pipe_if #(.FUNC_W(6), .ALU_OP_W(3), .CTRL_W(4)) bus ();

    alu_control_pipe #(.FUNC_W(6), .ALU_OP_W(3), .CTRL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    typedef struct {
        logic [2:0] op;
        logic [5:0] fn;
        logic [3:0] ctrl;
        logic       ill;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op,
                         input logic [5:0] fn);
        bus.valid_in = v;
        bus.alu_op   = op;
        bus.func     = fn;
    endtask

    initial begin
        vecs[0]  = '{3'b000, 6'b000000, 4'b0010, 1'b0};
        vecs[1]  = '{3'b001, 6'b000000, 4'b0110, 1'b0};
        vecs[2]  = '{3'b011, 6'b000000, 4'b0000, 1'b0};
        vecs[3]  = '{3'b100, 6'b000000, 4'b0001, 1'b0};
        vecs[4]  = '{3'b101, 6'b000000, 4'b0111, 1'b0};
        vecs[5]  = '{3'b110, 6'b000000, 4'b1010, 1'b0};
        vecs[6]  = '{3'b111, 6'b000000, 4'b0010, 1'b1};
        vecs[7]  = '{3'b010, 6'b100000, 4'b0010, 1'b0};
        vecs[8]  = '{3'b010, 6'b100100, 4'b0000, 1'b0};
        vecs[9]  = '{3'b010, 6'b100101, 4'b0001, 1'b0};
        vecs[10] = '{3'b010, 6'b100111, 4'b1100, 1'b0};
        vecs[11] = '{3'b010, 6'b100010, 4'b0110, 1'b0};
        vecs[12] = '{3'b010, 6'b101010, 4'b0111, 1'b0};
        vecs[13] = '{3'b010, 6'b000000, 4'b1000, 1'b0};
        vecs[14] = '{3'b010, 6'b000010, 4'b1001, 1'b0};
        vecs[15] = '{3'b010, 6'b010000, 4'b1111, 1'b0};
        vecs[16] = '{3'b010, 6'b010010, 4'b1111, 1'b0};
        vecs[17] = '{3'b010, 6'b111111, 4'b0010, 1'b1};

        drive(1'b0, 3'b000, 6'b000000);
        bus.stall_in = 1'b0;
        bus.md_done  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_valid_out", bus.valid_out, 0);
        chk("rst_alu_ctrl", bus.alu_ctrl, 0);
        chk("rst_illegal", bus.illegal, 0);
        chk("rst_md_start", bus.md_start, 0);
        chk("rst_md_op", bus.md_op, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.ready_out, 1);

        // single sub beat, then bubble
        drive(1'b1, 3'b010, 6'b100010);
        tick();
        drive(1'b0, 3'b000, 6'b000000);
        chk("sub_valid", bus.valid_out, 1);
        chk("sub_ctrl", bus.alu_ctrl, 4'b0110);
        chk("sub_ill", bus.illegal, 0);
        tick();
        chk("sub_drop", bus.valid_out, 0);

        // back-to-back decode table
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("tbl%0d_ready", i), bus.ready_out, 1);
            drive(1'b1, vecs[i].op, vecs[i].fn);
            tick();
            chk($sformatf("tbl%0d_valid", i), bus.valid_out, 1);
            chk($sformatf("tbl%0d_ctrl", i), bus.alu_ctrl, vecs[i].ctrl);
            chk($sformatf("tbl%0d_ill", i), bus.illegal, vecs[i].ill);
        end
        drive(1'b0, 3'b000, 6'b000000);
        tick();
        chk("tbl_drop", bus.valid_out, 0);

        // stall holds the slt beat for three cycles
        drive(1'b1, 3'b010, 6'b101010);
        tick();
        chk("slt_ctrl", bus.alu_ctrl, 4'b0111);
        bus.stall_in = 1'b1;
        drive(1'b1, 3'b010, 6'b100101);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d_ready", i), bus.ready_out, 0);
            tick();
            chk($sformatf("stall%0d_valid", i), bus.valid_out, 1);
            chk($sformatf("stall%0d_ctrl", i), bus.alu_ctrl, 4'b0111);
        end
        bus.stall_in = 1'b0;
        #1;
        chk("unstall_ready", bus.ready_out, 1);
        tick();
        drive(1'b0, 3'b000, 6'b000000);
        chk("unstall_valid", bus.valid_out, 1);
        chk("unstall_ctrl", bus.alu_ctrl, 4'b0001);
        tick();

        // mult launch and completion
        drive(1'b1, 3'b010, 6'b011000);
        tick();
        drive(1'b0, 3'b000, 6'b000000);
        chk("mult_start", bus.md_start, 1);
        chk("mult_op", bus.md_op, 0);
        chk("mult_busy", bus.busy, 1);
        chk("mult_ready", bus.ready_out, 0);
        chk("mult_nobeat", bus.valid_out, 0);
        tick();
        chk("mult_pulse", bus.md_start, 0);
        for (int i = 0; i < 8; i++) tick();
        chk("mult_wait_busy", bus.busy, 1);
        chk("mult_wait_valid", bus.valid_out, 0);
        bus.md_done = 1'b1;
        tick();
        bus.md_done = 1'b0;
        chk("mult_done_valid", bus.valid_out, 1);
        chk("mult_done_ctrl", bus.alu_ctrl, 4'b1111);
        chk("mult_done_ill", bus.illegal, 0);
        chk("mult_done_busy", bus.busy, 0);
        chk("mult_done_ready", bus.ready_out, 1);
        tick();
        chk("mult_done_drop", bus.valid_out, 0);

        // div, then reset while waiting
        drive(1'b1, 3'b010, 6'b011010);
        tick();
        drive(1'b0, 3'b000, 6'b000000);
        chk("div_start", bus.md_start, 1);
        chk("div_op", bus.md_op, 1);
        tick();
        tick();
        chk("div_busy", bus.busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("divrst_busy", bus.busy, 0);
        chk("divrst_valid", bus.valid_out, 0);
        chk("divrst_ready", bus.ready_out, 1);
        bus.md_done = 1'b1;
        tick();
        bus.md_done = 1'b0;
        chk("stray_valid", bus.valid_out, 0);
        chk("stray_busy", bus.busy, 0);
        tick();
        chk("stray_valid2", bus.valid_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
